// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_pkg
// Purpose: Shared types for the main-memory port arbiter: the data word, the
//          arbiter FSM state, the access owner and the latched request.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  typedef logic [15:0] uword;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } arb_owner_t;

  // One latched request, frozen for the duration of an access.
  typedef struct packed {
    logic wr;
    uword addr;
    uword wdata;
  } mem_req_t;

  // Latency counter width; holds RD_LAT-1 for RD_LAT up to 4.
  localparam int LAT_W = 3;

  // Starvation counter width; holds MAX_WAIT up to 15.
  localparam int WAIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module : arb_starve_cnt
// Purpose: Saturating count of consecutive arbitration rounds in which port B
//          was denied. The saturation flag forces the next grant to port B.
// Ports  : clk, rst          - clock, async active-high reset
//          inc               - B denied this round (saturates at MAX_WAIT)
//          clr               - B granted this round (clear has priority)
//          cnt               - current wait count
//          sat               - cnt == MAX_WAIT
// Rev    : 1.0  initial release
// ============================================================================
module arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] cnt,
  output logic              sat
);

  localparam logic [WAIT_W-1:0] C_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Purpose: Shares single-port main memory between port A (load/store, high
//          priority) and port B (fetch/loader). Each access is latched,
//          sequenced through RD_LAT cycles of read latency and answered with
//          a one-cycle done pulse. A starvation counter forces a B grant after
//          MAX_WAIT consecutive denials.
// Ports  : clk, rst                       - clock, async active-high reset
//          halt_sys                       - blocks new grants
//          a_req/a_wr/a_addr/a_wdata      - port A request
//          a_done/a_rdata/a_stall         - port A response, pipeline freeze
//          b_req/b_wr/b_addr/b_wdata      - port B request
//          b_done/b_rdata                 - port B response
//          mem_write_en/mem_address/
//          mem_write_data/mem_data        - main memory interface
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [15:0] a_addr,
  input  uword        a_wdata,
  output logic        a_done,
  output logic [15:0] a_rdata,
  output logic        a_stall,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_done,
  output logic [15:0] b_rdata,
  output logic        mem_write_en,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_data
);

  localparam logic [LAT_W-1:0] C_LAT_INIT = LAT_W'(RD_LAT - 1);

  arb_state_t        state_q,   state_d;
  arb_owner_t        owner_q,   owner_d;
  mem_req_t          req_q,     req_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  uword              a_rdata_q, a_rdata_d;
  uword              b_rdata_q, b_rdata_d;

  logic              wait_inc;
  logic              wait_clr;
  logic              wait_sat;
  logic [WAIT_W-1:0] wait_cnt;

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .clr (wait_clr),
    .cnt (wait_cnt),
    .sat (wait_sat)
  );

  // Next-state, request latch and read-data capture.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    req_d     = req_q;
    lat_cnt_d = lat_cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!halt_sys) begin
          // B wins when A is quiet or when B has waited long enough.
          if (b_req && (!a_req || wait_sat)) begin
            owner_d   = OWN_B;
            req_d     = '{wr: b_wr, addr: b_addr, wdata: b_wdata};
            lat_cnt_d = C_LAT_INIT;
            wait_clr  = 1'b1;
            state_d   = ACCESS;
          end else if (a_req) begin
            owner_d   = OWN_A;
            req_d     = '{wr: a_wr, addr: a_addr, wdata: a_wdata};
            lat_cnt_d = C_LAT_INIT;
            wait_inc  = b_req;
            state_d   = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (req_q.wr) begin
          // Writes take a single ACCESS cycle regardless of read latency.
          state_d = RESP;
        end else if (lat_cnt_q == '0) begin
          if (owner_q == OWN_B) begin
            b_rdata_d = mem_data;
          end else begin
            a_rdata_d = mem_data;
          end
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_A;
      req_q     <= '0;
      lat_cnt_q <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      lat_cnt_q <= lat_cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Memory outputs decode straight from registered state so that reset
  // removes them immediately. A write spends exactly one cycle in ACCESS,
  // which yields exactly one write-enable pulse per write.
  logic in_access;
  assign in_access      = (state_q == ACCESS);
  assign mem_write_en   = in_access && req_q.wr;
  assign mem_address    = in_access ? req_q.addr  : 16'h0000;
  assign mem_write_data = in_access ? req_q.wdata : 16'h0000;

  assign a_done  = (state_q == RESP) && (owner_q == OWN_A);
  assign b_done  = (state_q == RESP) && (owner_q == OWN_B);
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign a_stall = a_req && !a_done;

  // The wait count is observed through the saturation flag only.
  logic unused_wait_cnt;
  assign unused_wait_cnt = ^wait_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Purpose: Directed self-checking bench for mem_port_arbiter. Two instances
//          (RD_LAT=1 and RD_LAT=3) share one stimulus set; each has its own
//          behavioural memory.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_sys;
  logic        a_req, a_wr, b_req, b_wr;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;

  logic        a_done1, a_stall1, b_done1, we1;
  logic [15:0] a_rdata1, b_rdata1, addr1, wd1, md1;
  logic        a_done3, a_stall3, b_done3, we3;
  logic [15:0] a_rdata3, b_rdata3, addr3, wd3, md3;

  logic        pl_we;
  logic [15:0] pl_addr, pl_data;
  logic [15:0] mem1 [0:65535];
  logic [15:0] mem3 [0:65535];
  int          wcnt1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LAT(1), .MAX_WAIT(4)) dut1 (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done1), .a_rdata(a_rdata1), .a_stall(a_stall1),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done1), .b_rdata(b_rdata1),
    .mem_write_en(we1), .mem_address(addr1), .mem_write_data(wd1),
    .mem_data(md1)
  );

  mem_port_arbiter #(.RD_LAT(3), .MAX_WAIT(4)) dut3 (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done3), .a_rdata(a_rdata3), .a_stall(a_stall3),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done3), .b_rdata(b_rdata3),
    .mem_write_en(we3), .mem_address(addr3), .mem_write_data(wd3),
    .mem_data(md3)
  );

  // Behavioural main memories: asynchronous read, write on the clock edge.
  assign md1 = mem1[addr1];
  assign md3 = mem3[addr3];

  always @(posedge clk) begin
    if (pl_we) begin
      mem1[pl_addr] <= pl_data;
      mem3[pl_addr] <= pl_data;
    end else begin
      if (we1) mem1[addr1] <= wd1;
      if (we3) mem3[addr3] <= wd3;
    end
  end

  always @(posedge clk) begin
    if (rst)      wcnt1 <= 0;
    else if (we1) wcnt1 <= wcnt1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic preload(input logic [15:0] ad, input logic [15:0] dt);
    pl_we   = 1'b1;
    pl_addr = ad;
    pl_data = dt;
    tick;
    pl_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] exp_seq;
    logic       seen;
    int         k;

    rst = 1'b1; halt_sys = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    tick;
    preload(16'h0010, 16'hBEEF);
    preload(16'h0011, 16'hCAFE);
    preload(16'h0020, 16'h2222);
    preload(16'h0040, 16'h0000);
    preload(16'h0050, 16'h5555);

    // Reset state
    check("rst_flags1", {31'd0, a_done1 | b_done1 | a_stall1 | we1}, 32'd0);
    check("rst_addr1",  {16'd0, addr1}, 32'd0);
    check("rst_wd1",    {16'd0, wd1}, 32'd0);
    check("rst_rdata1", {a_rdata1, b_rdata1}, 32'd0);
    check("rst_flags3", {31'd0, a_done3 | b_done3 | a_stall3 | we3}, 32'd0);
    rst = 1'b0;
    tick;

    // Port A read, RD_LAT=1
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0010;
    #1;
    check("t1_stall_c0", {31'd0, a_stall1}, 32'd1);
    tick;
    check("t1_addr_c1",  {16'd0, addr1}, 32'h0010);
    check("t1_stall_c1", {31'd0, a_stall1}, 32'd1);
    check("t1_done_c1",  {31'd0, a_done1}, 32'd0);
    tick;
    check("t1_done_c2",  {31'd0, a_done1}, 32'd1);
    check("t1_rdata_c2", {16'd0, a_rdata1}, 32'hBEEF);
    check("t1_stall_c2", {31'd0, a_stall1}, 32'd0);
    a_req = 1'b0;
    tick;
    check("t1_done_c3",  {31'd0, a_done1}, 32'd0);
    check("t1_hold_c3",  {16'd0, a_rdata1}, 32'hBEEF);

    // Port B write then port A read-back
    do_reset;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0040; b_wdata = 16'h1234;
    tick;
    check("t2_we_c1",    {31'd0, we1}, 32'd1);
    check("t2_addr_c1",  {16'd0, addr1}, 32'h0040);
    check("t2_wd_c1",    {16'd0, wd1}, 32'h1234);
    check("t2_bdone_c1", {31'd0, b_done1}, 32'd0);
    tick;
    check("t2_bdone_c2", {31'd0, b_done1}, 32'd1);
    check("t2_we_c2",    {31'd0, we1}, 32'd0);
    b_req = 1'b0; b_wr = 1'b0;
    tick;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0040;
    tick;
    tick;
    check("t2_adone",    {31'd0, a_done1}, 32'd1);
    check("t2_rdata",    {16'd0, a_rdata1}, 32'h1234);
    check("t2_brdata",   {16'd0, b_rdata1}, 32'h0000);
    a_req = 1'b0;
    check("t2_wr_count", wcnt1, 32'd1);

    // Continuous contention: A,A,A,A,B repeating (bit i = grant i, 1 = B)
    do_reset;
    exp_seq = 10'b10000_10000;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0010;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      k = 0;
      while (!(a_done1 | b_done1) && k < 10) begin
        tick;
        k++;
      end
      if (k >= 10) begin
        check($sformatf("t3_timeout_%0d", i), 32'd1, 32'd0);
      end else begin
        check($sformatf("t3_grant_%0d", i), {31'd0, b_done1}, {31'd0, exp_seq[i]});
      end
      tick;
    end
    a_req = 1'b0; b_req = 1'b0;
    check("t3_brdata", {16'd0, b_rdata1}, 32'h2222);

    // halt_sys during ACCESS of an A read
    do_reset;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0011;
    tick;
    halt_sys = 1'b1;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0020;
    tick;
    check("t4_adone",  {31'd0, a_done1}, 32'd1);
    check("t4_ardata", {16'd0, a_rdata1}, 32'hCAFE);
    a_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      seen = seen | b_done1 | a_done1 | we1;
    end
    check("t4_halt_nogrant", {31'd0, seen}, 32'd0);
    halt_sys = 1'b0;
    tick;
    check("t4_b_addr",  {16'd0, addr1}, 32'h0020);
    check("t4_bdone0",  {31'd0, b_done1}, 32'd0);
    tick;
    check("t4_bdone1",  {31'd0, b_done1}, 32'd1);
    check("t4_brdata",  {16'd0, b_rdata1}, 32'h2222);
    b_req = 1'b0;

    // Reset in the ACCESS cycle of a B write, RD_LAT=3
    do_reset;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0050; b_wdata = 16'hAAAA;
    tick;
    check("t5_we_pre", {31'd0, we3}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_we_rst",   {31'd0, we3}, 32'd0);
    check("t5_addr_rst", {16'd0, addr3}, 32'd0);
    check("t5_wd_rst",   {16'd0, wd3}, 32'd0);
    check("t5_done_rst", {31'd0, b_done3}, 32'd0);
    b_req = 1'b0; b_wr = 1'b0;
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      seen = seen | b_done3 | we3;
    end
    check("t5_no_done", {31'd0, seen}, 32'd0);
    check("t5_mem_kept", {16'd0, mem3[16'h0050]}, 32'h5555);

    // RD_LAT=3 A reads: done 4 cycles after grant, rdata holds
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0010;
    tick;
    tick;
    tick;
    check("t6_done_c3",  {31'd0, a_done3}, 32'd0);
    check("t6_rdata_c3", {16'd0, a_rdata3}, 32'h0000);
    tick;
    check("t6_done_c4",  {31'd0, a_done3}, 32'd1);
    check("t6_rdata_c4", {16'd0, a_rdata3}, 32'hBEEF);
    a_req = 1'b0; a_addr = 16'h0011;
    tick;
    a_req = 1'b1;
    tick;
    check("t6_hold_c6",  {16'd0, a_rdata3}, 32'hBEEF);
    tick;
    tick;
    check("t6_hold_c8",  {16'd0, a_rdata3}, 32'hBEEF);
    check("t6_done_c8",  {31'd0, a_done3}, 32'd0);
    tick;
    check("t6_done_c9",  {31'd0, a_done3}, 32'd1);
    check("t6_rdata_c9", {16'd0, a_rdata3}, 32'hCAFE);
    a_req = 1'b0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory (mem_main) between two requesters: port A, the stage-three load/store path, and port B, the instruction-fetch / program-loader path.
- Port A has priority. A starvation counter guarantees port B eventual service.
- Sequences each access through a fixed read latency and returns read data with a one-cycle valid pulse.
- Sits between the pipeline stages and mem_main, and drives mem_main's write_en, address and write_data.

Parameters:
- RD_LAT, 1: cycles from address presentation to mem_data being valid. Legal range 1..4.
- MAX_WAIT, 4: consecutive cycles port B may be denied before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- halt_sys  in  1  system halt; no new grants while high
- a_req  in  1  port A access request, held until a_done
- a_wr  in  1  port A write (1) / read (0)
- a_addr  in  16  port A word address
- a_wdata  in  16  port A write data (types_pkg::uword)
- a_done  out  1  one-cycle completion pulse for port A
- a_rdata  out  16  port A read data, valid when a_done=1 and the access was a read
- a_stall  out  1  a_req & ~a_done (pipeline freeze)
- b_req  in  1  port B access request, held until b_done
- b_wr  in  1  port B write / read
- b_addr  in  16  port B word address
- b_wdata  in  16  port B write data
- b_done  out  1  one-cycle completion pulse for port B
- b_rdata  out  16  port B read data
- mem_write_en  out  1  to mem_main write_en
- mem_address  out  16  to mem_main address
- mem_write_data  out  16  to mem_main write_data
- mem_data  in  16  from mem_main data_out

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=A, lat_cnt=0, wait_cnt=0. All outputs 0; mem_address=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If halt_sys=1, remain in IDLE. No grant is issued and wait_cnt holds its value.
  - Otherwise select the owner:
    - B, if b_req & (~a_req | wait_cnt==MAX_WAIT);
    - else A, if a_req;
    - else stay in IDLE.
  - On a grant: latch wr, addr and wdata of the chosen port, set lat_cnt=RD_LAT-1, go to ACCESS.
- ACCESS:
  - mem_address = latched addr; mem_write_data = latched wdata.
  - mem_write_en=1 only on the first ACCESS cycle of a write, so each access produces exactly one write.
  - A write skips the latency count and goes to RESP next cycle.
  - A read decrements lat_cnt each cycle. When lat_cnt==0, capture mem_data into the owner's rdata register and go to RESP.
- RESP:
  - Owner's done=1 for exactly this cycle; the rdata register holds its value until the next read completes on that port.
  - Next state is IDLE. Back-to-back accesses are separated by one IDLE cycle.
- Latency per access:
  - Read: grant cycle, then RD_LAT ACCESS cycles, then RESP. done asserts RD_LAT+1 cycles after the grant edge.
  - Write: done asserts 2 cycles after the grant edge.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each IDLE cycle where b_req=1, halt_sys=0, and A is granted.
  - Clears to 0 when B is granted.
  - Holds in all other cycles.
- Simultaneous a_req and b_req with wait_cnt<MAX_WAIT: A wins.
- Simultaneous a_req and b_req with wait_cnt==MAX_WAIT: B wins.
- halt_sys asserted during ACCESS or RESP: the in-flight access completes normally; only new grants are blocked.
- Request dropped mid-access: not permitted (protocol violation). The access still completes and done still pulses.
- Reset mid-access: the access is aborted immediately. No done pulse. mem_write_en drops asynchronously.
- a_stall is combinational: a_req & ~a_done.

Decomposition:
- Add to types_pkg:
  - arb_state_t enum {IDLE, ACCESS, RESP};
  - arb_owner_t enum {OWN_A, OWN_B};
  - mem_req_t struct {wr, addr, wdata} (one latched request).
- Sub-module arb_starve_cnt: saturating wait counter with inc/clr/sat-flag outputs, parameterised by MAX_WAIT.

Test Plan:
- Port A read only, RD_LAT=1, mem[0x0010]=0xBEEF: a_req at cycle 0 → mem_address=0x0010 in cycle 1; a_done=1 in cycle 2 with a_rdata=0xBEEF; a_stall high in cycles 0–1.
- Port B write 0x1234 to 0x0040, then port A read of 0x0040 → exactly one mem_write_en pulse; b_done at grant+2; A's subsequent read returns 0x1234.
- a_req and b_req held continuously, MAX_WAIT=4 → grant sequence A,A,A,A,B,A,A,A,A,B…; wait_cnt peaks at 4 and clears when B is granted.
- halt_sys rises during the ACCESS of a port A read → read completes with a_done; no new grant while halt_sys=1; the pending b_req is granted on the first IDLE cycle after halt_sys falls.
- rst pulsed during ACCESS of a port B write with RD_LAT=3 → all outputs 0 immediately; no b_done; state=IDLE after release.
- RD_LAT=3 read by port A → a_done exactly 4 cycles after the grant edge; a_rdata holds its value until the next port A read completes.
